v3a_queue_op_adapter: RTL and testbench

Upstream client adapter for the v3a queue controller. It accepts one tagged queue operation at a time over a val/rdy request channel and drives exactly one of the controller's six `*_en` lines with the en/cpl protocol. It captures the returned tag or data and presents it on a val/rdy response channel. An optional watchdog aborts operations the controller never completes, for example enq on full or deq on empty.

---
 rtl/v3a_queue_pkg.sv | 27 ++
 rtl/v3a_op_timer.sv | 34 +++
 rtl/v3a_queue_op_adapter.sv | 180 ++++++++++++++++++
 tb/tb_v3a_queue_op_adapter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/v3a_queue_pkg.sv
// Shared types for the v3a queue controller and its client adapter.
// Build option: V3A_QUEUE_OP_ADAPTER_TIMEOUT_EN (watchdog in the adapter).
package v3a_queue_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ENQ_BACK  = 3'd0,
    OP_ENQ_FRONT = 3'd1,
    OP_DEQ_BACK  = 3'd2,
    OP_DEQ_FRONT = 3'd3,
    OP_UPD       = 3'd4,
    OP_DEL       = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } adp_state_e;

  // Codes 6 and 7 have no controller line behind them.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_DEL;
  endfunction

endpackage

// File: rtl/v3a_op_timer.sv
// Clearable saturating cycle counter; done_o is high once p_limit cycles
// of en_i have elapsed since the last clear.
// Used by v3a_queue_op_adapter only when V3A_QUEUE_OP_ADAPTER_TIMEOUT_EN is defined.
module v3a_op_timer #(
  parameter int p_limit = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = $clog2(p_limit + 1);
  localparam logic [CW-1:0] LIM = CW'(p_limit);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != LIM) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == LIM);

endmodule

// File: rtl/v3a_queue_op_adapter.sv
// Client adapter for the v3a queue controller: one tagged op at a time,
// val/rdy request in, en/cpl handshake to the controller, val/rdy response out.
// Build option: V3A_QUEUE_OP_ADAPTER_TIMEOUT_EN adds a watchdog that aborts
// ops the controller never completes (enq on full, deq on empty).
module v3a_queue_op_adapter
  import v3a_queue_pkg::*;
#(
  parameter int p_depth     = 32,
  parameter int p_ptrwidth  = $clog2(p_depth),
  parameter int p_chanwidth = 32,
  parameter int p_timeout   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [OP_W-1:0]        req_op,
  input  logic [p_ptrwidth-1:0]  req_tag,
  input  logic [p_chanwidth-1:0] req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [OP_W-1:0]        resp_op,
  output logic                   resp_ok,
  output logic [p_ptrwidth-1:0]  resp_tag,
  output logic [p_chanwidth-1:0] resp_data,
  output logic                   q_enq_back_en,
  output logic                   q_enq_front_en,
  output logic                   q_deq_back_en,
  output logic                   q_deq_front_en,
  output logic                   q_upd_en,
  output logic                   q_del_en,
  input  logic                   q_enq_back_cpl,
  input  logic                   q_enq_front_cpl,
  input  logic                   q_deq_back_cpl,
  input  logic                   q_deq_front_cpl,
  input  logic                   q_upd_cpl,
  input  logic                   q_del_cpl,
  input  logic [p_ptrwidth-1:0]  q_enq_back_tag,
  input  logic [p_ptrwidth-1:0]  q_enq_front_tag,
  input  logic [p_chanwidth-1:0] q_deq_back_data,
  input  logic [p_chanwidth-1:0] q_deq_front_data,
  output logic [p_chanwidth-1:0] q_enq_data,
  output logic [p_ptrwidth-1:0]  q_upd_tag,
  output logic [p_ptrwidth-1:0]  q_del_tag,
  output logic [p_chanwidth-1:0] q_upd_data
);

  // A watchdog shorter than a full-queue tag search would abort legal upd/del.
  if (p_timeout < 2 * p_depth + 4) begin : g_bad_timeout
    $error("p_timeout must be at least 2*p_depth+4");
  end

  adp_state_e             state_q, state_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [p_ptrwidth-1:0]  tag_q, tag_d;
  logic [p_chanwidth-1:0] data_q, data_d;
  logic                   resp_ok_q, resp_ok_d;
  logic [p_ptrwidth-1:0]  resp_tag_q, resp_tag_d;
  logic [p_chanwidth-1:0] resp_data_q, resp_data_d;
  logic                   accept, cpl_sel, tmo, en_sel;

  assign accept = (state_q == ST_IDLE) && req_val;

`ifdef V3A_QUEUE_OP_ADAPTER_TIMEOUT_EN
  v3a_op_timer #(.p_limit(p_timeout)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (state_q == ST_ISSUE),
    .done_o (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // Completion of the op in flight; completions on other lines are ignored.
  always_comb begin
    cpl_sel = 1'b0;
    case (op_q)
      OP_ENQ_BACK:  cpl_sel = q_enq_back_cpl;
      OP_ENQ_FRONT: cpl_sel = q_enq_front_cpl;
      OP_DEQ_BACK:  cpl_sel = q_deq_back_cpl;
      OP_DEQ_FRONT: cpl_sel = q_deq_front_cpl;
      OP_UPD:       cpl_sel = q_upd_cpl;
      OP_DEL:       cpl_sel = q_del_cpl;
      default:      cpl_sel = 1'b0;
    endcase
  end

  // Next state, request latch and response capture; completion beats timeout.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tag_d       = tag_q;
    data_d      = data_q;
    resp_ok_d   = resp_ok_q;
    resp_tag_d  = resp_tag_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          op_d      = req_op;
          tag_d     = req_tag;
          data_d    = req_data;
          resp_ok_d = 1'b0;
          state_d   = op_legal(req_op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        if (cpl_sel) begin
          resp_ok_d = 1'b1;
          case (op_q)
            OP_ENQ_BACK:  resp_tag_d  = q_enq_back_tag;
            OP_ENQ_FRONT: resp_tag_d  = q_enq_front_tag;
            OP_DEQ_BACK:  resp_data_d = q_deq_back_data;
            OP_DEQ_FRONT: resp_data_d = q_deq_front_data;
            default: ;
          endcase
          state_d = ST_RESP;
        end else if (tmo) begin
          resp_ok_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_rdy) begin
          resp_ok_d   = 1'b0;
          resp_tag_d  = '0;
          resp_data_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      resp_ok_q   <= 1'b0;
      resp_tag_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      resp_ok_q   <= resp_ok_d;
      resp_tag_q  <= resp_tag_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Enable falls combinationally with cpl so an enq/deq cannot fire twice
  // and an upd/del search is never restarted.
  assign en_sel         = (state_q == ST_ISSUE) && !cpl_sel && !tmo;
  assign q_enq_back_en  = en_sel && (op_q == OP_ENQ_BACK);
  assign q_enq_front_en = en_sel && (op_q == OP_ENQ_FRONT);
  assign q_deq_back_en  = en_sel && (op_q == OP_DEQ_BACK);
  assign q_deq_front_en = en_sel && (op_q == OP_DEQ_FRONT);
  assign q_upd_en       = en_sel && (op_q == OP_UPD);
  assign q_del_en       = en_sel && (op_q == OP_DEL);

  assign q_enq_data = data_q;
  assign q_upd_data = data_q;
  assign q_upd_tag  = tag_q;
  assign q_del_tag  = tag_q;

  assign req_rdy   = (state_q == ST_IDLE) && !rst;
  assign resp_val  = (state_q == ST_RESP);
  assign resp_op   = resp_val ? op_q : '0;
  assign resp_ok   = resp_ok_q;
  assign resp_tag  = resp_tag_q;
  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_v3a_queue_op_adapter.sv
// Directed bench for v3a_queue_op_adapter with a registered controller model.
// The timeout case runs only when V3A_QUEUE_OP_ADAPTER_TIMEOUT_EN is defined.
module tb_v3a_queue_op_adapter;

  localparam int PW = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_val, req_rdy, resp_val, resp_rdy, resp_ok;
  logic [2:0]    req_op, resp_op;
  logic [PW-1:0] req_tag, resp_tag;
  logic [CW-1:0] req_data, resp_data;
  logic          q_enq_back_en, q_enq_front_en, q_deq_back_en, q_deq_front_en, q_upd_en, q_del_en;
  logic [PW-1:0] q_enq_back_tag, q_enq_front_tag, q_upd_tag, q_del_tag;
  logic [CW-1:0] q_deq_back_data, q_deq_front_data, q_enq_data, q_upd_data;
  logic [5:0]    en_v, cpl_v, cpl_next;

  int n_cmp = 0;
  int n_bad = 0;
  int run   = 0;
  int lat_m = 0;
  int en_cnt [6] = '{0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  v3a_queue_op_adapter #(
    .p_depth(4), .p_ptrwidth(PW), .p_chanwidth(CW), .p_timeout(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_tag(req_tag), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_ok(resp_ok),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .q_enq_back_en(q_enq_back_en), .q_enq_front_en(q_enq_front_en),
    .q_deq_back_en(q_deq_back_en), .q_deq_front_en(q_deq_front_en),
    .q_upd_en(q_upd_en), .q_del_en(q_del_en),
    .q_enq_back_cpl(cpl_v[0]), .q_enq_front_cpl(cpl_v[1]),
    .q_deq_back_cpl(cpl_v[2]), .q_deq_front_cpl(cpl_v[3]),
    .q_upd_cpl(cpl_v[4]), .q_del_cpl(cpl_v[5]),
    .q_enq_back_tag(q_enq_back_tag), .q_enq_front_tag(q_enq_front_tag),
    .q_deq_back_data(q_deq_back_data), .q_deq_front_data(q_deq_front_data),
    .q_enq_data(q_enq_data), .q_upd_tag(q_upd_tag), .q_del_tag(q_del_tag), .q_upd_data(q_upd_data)
  );

  // Bit index of each enable equals its op code.
  assign en_v = {q_del_en, q_upd_en, q_deq_front_en, q_deq_back_en, q_enq_front_en, q_enq_back_en};

  // Controller model: completes after lat_m consecutive enable cycles (0 = never).
  always @(negedge clk) begin
    if (en_v != 6'd0) begin
      run = run + 1;
      for (int i = 0; i < 6; i++) if (en_v[i]) en_cnt[i] = en_cnt[i] + 1;
      cpl_next = (lat_m != 0 && run == lat_m) ? en_v : 6'd0;
    end else begin
      run      = 0;
      cpl_next = 6'd0;
    end
  end

  // Completions are registered in the controller: visible just after the edge.
  initial cpl_v = 6'd0;
  always @(posedge clk) begin
    #1;
    cpl_v = cpl_next;
  end

  typedef struct {
    logic [2:0]    op;
    logic [PW-1:0] tag;
    logic [CW-1:0] data;
    int            lat;
    logic [PW-1:0] btag, ftag;
    logic [CW-1:0] bdata, fdata;
    logic          ok;
    logic [PW-1:0] etag;
    logic [CW-1:0] edata;
    int            ecyc;   // cycles after acceptance until resp_val
    int            een;    // cycles the selected enable is high
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rdy();
    int c = 0;
    while (req_rdy !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("req_rdy_idle", req_rdy, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    int base [6];
    wait_rdy();
    lat_m            = v.lat;
    q_enq_back_tag   = v.btag;
    q_enq_front_tag  = v.ftag;
    q_deq_back_data  = v.bdata;
    q_deq_front_data = v.fdata;
    for (int i = 0; i < 6; i++) base[i] = en_cnt[i];
    req_val  = 1'b1;
    req_op   = v.op;
    req_tag  = v.tag;
    req_data = v.data;
    @(negedge clk);
    req_val = 1'b0;
    c = 1;
    while (resp_val !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("resp_cycle", 64'(c), 64'(v.ecyc));
    chk("resp_ok", resp_ok, v.ok);
    chk("resp_op", resp_op, v.op);
    chk("resp_tag", resp_tag, v.etag);
    chk("resp_data", resp_data, v.edata);
    chk("req_rdy_busy", req_rdy, 0);
    for (int i = 0; i < 6; i++)
      chk("en_cycles", 64'(en_cnt[i] - base[i]), (64'(i) == 64'(v.op)) ? 64'(v.een) : 64'd0);
    chk("q_data_out", q_enq_data ^ q_upd_data ^ v.data, v.data);
    chk("q_tag_out", {q_upd_tag, q_del_tag}, {v.tag, v.tag});
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("resp_cleared", {resp_val, resp_ok, resp_op, resp_tag, 32'(resp_data != 0)}, 0);
  endtask

  initial begin
    logic ok_flag;
    int   sum0;
    rst = 1'b1; req_val = 1'b0; req_op = '0; req_tag = '0; req_data = '0; resp_rdy = 1'b0;
    q_enq_back_tag = '0; q_enq_front_tag = '0; q_deq_back_data = '0; q_deq_front_data = '0;

    //        op    tag    data          lat btag ftag bdata         fdata         ok    etag  edata         cyc en
    vt[0] = '{3'd0, 2'd0, 32'h0000_00AB, 1, 2'd0, 2'd3, 32'h0,        32'h0,        1'b1, 2'd0, 32'h0,        3, 1};
    vt[1] = '{3'd1, 2'd0, 32'h0000_0011, 1, 2'd2, 2'd1, 32'h0,        32'h0,        1'b1, 2'd1, 32'h0,        3, 1};
    vt[2] = '{3'd2, 2'd0, 32'h0,         1, 2'd3, 2'd3, 32'h0000_0011, 32'h0000_0099, 1'b1, 2'd0, 32'h0000_0011, 3, 1};
    vt[3] = '{3'd4, 2'd1, 32'h0000_0055, 5, 2'd3, 2'd3, 32'h7,        32'h7,        1'b1, 2'd0, 32'h0,        7, 5};
    vt[4] = '{3'd5, 2'd2, 32'h0,         3, 2'd1, 2'd1, 32'h7,        32'h7,        1'b1, 2'd0, 32'h0,        5, 3};
    vt[5] = '{3'd3, 2'd0, 32'h0,         1, 2'd0, 2'd0, 32'h0000_0077, 32'hDEAD_BEEF, 1'b1, 2'd0, 32'hDEAD_BEEF, 3, 1};
    vt[6] = '{3'd6, 2'd3, 32'h1,         1, 2'd1, 2'd1, 32'h5,        32'h5,        1'b0, 2'd0, 32'h0,        1, 0};
    vt[7] = '{3'd7, 2'd1, 32'h2,         1, 2'd1, 2'd1, 32'h5,        32'h5,        1'b0, 2'd0, 32'h0,        1, 0};

    // Reset state.
    #12;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp", {resp_val, resp_ok, resp_op, resp_tag, 32'(resp_data != 0)}, 0);
    chk("rst_en", en_v, 0);
    chk("rst_q_data", q_enq_data | q_upd_data, 0);
    chk("rst_q_tag", {q_upd_tag, q_del_tag}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

`ifdef V3A_QUEUE_OP_ADAPTER_TIMEOUT_EN
    // Deq_front on an empty queue: controller never completes.
    run_vec('{3'd3, 2'd0, 32'h0, 0, 2'd1, 2'd1, 32'h1234, 32'h5678, 1'b0, 2'd0, 32'h0, 18, 16});
`endif

    // Illegal op with the response stalled for 10 cycles.
    wait_rdy();
    sum0 = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] + en_cnt[4] + en_cnt[5];
    req_val = 1'b1; req_op = 3'd7; req_tag = 2'd2; req_data = 32'h99;
    @(negedge clk);
    req_val = 1'b0;
    chk("stall_resp_val", resp_val, 1);
    ok_flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(resp_val === 1'b1 && resp_ok === 1'b0 && resp_op === 3'd7 && req_rdy === 1'b0 &&
            resp_tag === '0 && resp_data === '0)) ok_flag = 1'b0;
    end
    chk("stall_stable", ok_flag, 1);
    chk("stall_no_en", 64'(en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] + en_cnt[4] + en_cnt[5]), 64'(sum0));
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("stall_release", resp_val, 0);

    // Reset in the middle of an upd search.
    wait_rdy();
    lat_m = 0;
    req_val = 1'b1; req_op = 3'd4; req_tag = 2'd3; req_data = 32'h1234;
    @(negedge clk);
    req_val = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_upd_en", q_upd_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_en", en_v, 0);
    chk("rst_async_rdy", req_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", req_rdy, 1);
    chk("post_rst_tag", q_upd_tag, 0);
    ok_flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_val !== 1'b0 || en_v !== 6'd0) ok_flag = 1'b1;
    end
    chk("post_rst_quiet", ok_flag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
